// File: rtl/bsg_read_hold_dff_pkg.sv
// Shared helpers for the read-hold stage and its flop primitives.
// The helper keeps port ranges legal when a width parameter is zero.
package bsg_read_hold_dff_pkg;

    // Returns a-b, or 0 when that would go negative. This lets a zero width elaborate as [0:0].
    function automatic int bsg_safe_minus(input int a, input int b);
        return (a > b) ? (a - b) : 0;
    endfunction

endpackage

// File: rtl/bsg_dff_en_bypass_reset_n.sv
// Enable-gated flop whose output bypasses straight to the input while enabled.
// When the enable is low, the input is ignored entirely, so X on data_i cannot leak out.
module bsg_dff_en_bypass_reset_n
    import bsg_read_hold_dff_pkg::*;
#(
    parameter int width_p     = 1,
    parameter int reset_val_p = 0
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 en_i,
    input  logic [bsg_safe_minus(width_p, 1):0] data_i,
    output logic [bsg_safe_minus(width_p, 1):0] data_o
);

    localparam int MsbLp = bsg_safe_minus(width_p, 1);
    localparam logic [MsbLp:0] ResetValLp = (MsbLp + 1)'(reset_val_p);

    logic [MsbLp:0] data_q;
    logic [MsbLp:0] data_d;

    // The next-state value and the output are the same mux.
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_q <= ResetValLp;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_d;

endmodule

// File: rtl/bsg_dff_reset_n.sv
// Generic flop with asynchronous active-low reset to a parameterised value.
module bsg_dff_reset_n
    import bsg_read_hold_dff_pkg::*;
#(
    parameter int width_p     = 1,
    parameter int reset_val_p = 0
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [bsg_safe_minus(width_p, 1):0] data_i,
    output logic [bsg_safe_minus(width_p, 1):0] data_o
);

    localparam int MsbLp = bsg_safe_minus(width_p, 1);
    localparam logic [MsbLp:0] ResetValLp = (MsbLp + 1)'(reset_val_p);

    logic [MsbLp:0] data_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_q <= ResetValLp;
        end else begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_read_hold_dff.sv
// Holds the last sync-RAM read result so the output stays valid on idle and write cycles.
// Fresh data bypasses through in the cycle it arrives.
module bsg_read_hold_dff
    import bsg_read_hold_dff_pkg::*;
#(
    parameter int width_p     = 32,
    parameter int reset_val_p = 0
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 read_en_i,
    input  logic [bsg_safe_minus(width_p, 1):0] data_i,
    output logic [bsg_safe_minus(width_p, 1):0] data_o
);

    generate
        if (width_p == 0) begin : g_zero
            logic unused_inputs;
            assign unused_inputs = ^{clk_i, reset_n_i, read_en_i, data_i};
            assign data_o        = '0;
        end else begin : g_data
            // read_en_q marks the cycle in which the RAM presents the data it was asked for.
            logic read_en_q;

            bsg_dff_reset_n #(
                .width_p    (1),
                .reset_val_p(0)
            ) read_en_reg (
                .clk_i    (clk_i),
                .reset_n_i(reset_n_i),
                .data_i   (read_en_i),
                .data_o   (read_en_q)
            );

            bsg_dff_en_bypass_reset_n #(
                .width_p    (width_p),
                .reset_val_p(reset_val_p)
            ) data_reg (
                .clk_i    (clk_i),
                .reset_n_i(reset_n_i),
                .en_i     (read_en_q),
                .data_i   (data_i),
                .data_o   (data_o)
            );
        end
    endgenerate

endmodule

// File: tb/tb_bsg_read_hold_dff.sv
// Scoreboard bench for bsg_read_hold_dff: the driver predicts each cycle's output from a last-read model.
// A negedge monitor compares that prediction against the DUT output.
module tb_bsg_read_hold_dff;

    localparam int W  = 32;
    localparam int RV = 32'h0BAD_F00D;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         readEn;
    logic [W-1:0] dataIn;
    logic [W-1:0] dataOut;
    logic [0:0]   dataInZ;
    logic [0:0]   dataOutZ;

    always #5 clk = ~clk;

    bsg_read_hold_dff #(
        .width_p    (W),
        .reset_val_p(RV)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .read_en_i(readEn),
        .data_i   (dataIn),
        .data_o   (dataOut)
    );

    bsg_read_hold_dff #(
        .width_p    (0),
        .reset_val_p(RV)
    ) dutZero (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .read_en_i(readEn),
        .data_i   (dataInZ),
        .data_o   (dataOutZ)
    );

    logic [W-1:0] expQ[$];
    int           testsRun    = 0;
    int           testsFailed = 0;

    // The model tracks whether the RAM owes data this cycle and what was read most recently.
    bit           readOwed    = 1'b0;
    logic [W-1:0] lastRead    = W'(RV);
    logic [W-1:0] monExp;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Each call drives one cycle. When pulseReset is set, reset is asserted mid-cycle and released before the next edge.
    task automatic applyStimulus(input bit rd, input bit pulseReset, input logic [W-1:0] val);
        logic [W-1:0] exp;
        @(posedge clk);
        #1;
        readEn  = rd;
        dataIn  = readOwed ? val : 'x;
        dataInZ = 1'($urandom_range(0, 1));
        if (pulseReset) begin
            reset_n  = 1'b0;
            lastRead = W'(RV);
            exp      = W'(RV);
        end else if (readOwed) begin
            lastRead = val;
            exp      = val;
        end else begin
            exp = lastRead;
        end
        expQ.push_back(exp);
        readOwed = rd;
        if (pulseReset) begin
            #6;
            reset_n = 1'b1;
        end
    endtask

    task automatic holdReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            readEn  = 1'($urandom_range(0, 1));
            dataIn  = 'x;
            dataInZ = 1'b0;
            expQ.push_back(W'(RV));
            readOwed = 1'b0;
            lastRead = W'(RV);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("data_o", dataOut, monExp);
            checkOutput("data_o_w0", {31'b0, dataOutZ}, '0);
        end
    end

    initial begin
        reset_n = 1'b0;
        readEn  = 1'b0;
        dataIn  = 'x;
        dataInZ = 1'b0;

        holdReset(3);
        applyStimulus(1'b1, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0);

        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 32'hA5A5_0001);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0);

        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'd2);
        applyStimulus(1'b0, 1'b0, 32'd3);
        applyStimulus(1'b0, 1'b0, '0);

        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 32'h0000_1234);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0);

        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 32'h0000_0077);
        applyStimulus(1'b0, 1'b0, '0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), W'($urandom));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
